// File: rtl/bpd0_tourn_gen_if.sv
// Fetch/retire bundle between the core front end and the tournament predictor first stage.
interface bpd0_tourn_gen_if #(
    parameter int PC_W    = 64,
    parameter int LHIST_W = 10
);
    logic               load_fetch_i;
    logic               bpd_ch_we_i;
    logic               bpd_ch_brdir_i;
    logic               bpd_rt_we_i;
    logic               bpd_rt_brdir_i;
    logic [PC_W-1:0]    sp_pc_i;
    logic [PC_W-1:0]    cm_pc_i;
    logic               bpd_ready_o;
    logic               bpd_pht_choice_f1;
    logic [LHIST_W-1:0] bpd_bht_lochist_f1;

    modport master (
        output load_fetch_i, bpd_ch_we_i, bpd_ch_brdir_i, bpd_rt_we_i, bpd_rt_brdir_i,
        output sp_pc_i, cm_pc_i,
        input  bpd_ready_o, bpd_pht_choice_f1, bpd_bht_lochist_f1
    );

    modport slave (
        input  load_fetch_i, bpd_ch_we_i, bpd_ch_brdir_i, bpd_rt_we_i, bpd_rt_brdir_i,
        input  sp_pc_i, cm_pc_i,
        output bpd_ready_o, bpd_pht_choice_f1, bpd_bht_lochist_f1
    );
endinterface

// File: rtl/bpd0_tourn_gen.sv
// Tournament predictor first stage: local history table + choice table, init sweep, F1 registers.
// Optional macro BPD0_BYPASS_EN forwards a same-cycle retire update into the F1 registers.
module bpd0_tourn_gen_chk (
    input logic clock,
    input logic reset,
    input logic ready,
    input logic in_run
);
    // Ready must track the FSM being out of the initialisation sweep.
    a_ready_is_run: assert property (@(posedge clock) disable iff (reset) ready == in_run);
endmodule

module bpd0_tourn_gen #(
    parameter int PC_W        = 64,
    parameter int LHT_ENTRIES = 1024,
    parameter int LHIST_W     = 10,
    parameter int CH_ENTRIES  = 4096,
    parameter int CNT_W       = 2
) (
    input logic             clock,
    input logic             reset,
    bpd0_tourn_gen_if.slave bus
);
    localparam int LI      = $clog2(LHT_ENTRIES);
    localparam int CI      = $clog2(CH_ENTRIES);
    localparam int N_SWEEP = (LHT_ENTRIES > CH_ENTRIES) ? LHT_ENTRIES : CH_ENTRIES;
    localparam int SW      = $clog2(N_SWEEP);

    localparam logic [SW-1:0]    SWEEP_LAST = SW'(N_SWEEP - 1);
    localparam logic [SW-1:0]    SWEEP_ONE  = SW'(1);
    localparam logic [CNT_W-1:0] CNT_INIT   = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MIN    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Saturating up/down step of a choice counter.
    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cnt, input logic up);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (up) begin
            if (cnt != CNT_MAX) res = cnt + CNT_ONE;
            else                res = cnt;
        end else begin
            if (cnt != CNT_MIN) res = cnt - CNT_ONE;
            else                res = cnt;
        end
        return res;
    endfunction

    // Oldest outcome falls off the top, newest enters at the LSB.
    function automatic logic [LHIST_W-1:0] hist_shift(input logic [LHIST_W-1:0] hist, input logic dir);
        return {hist[LHIST_W-2:0], dir};
    endfunction

    state_e             state_r;
    state_e             state_s;
    logic [SW-1:0]      sweep_cnt_r;
    logic               ready_r;
    logic [LHIST_W-1:0] lht_r [LHT_ENTRIES];
    logic [CNT_W-1:0]   ch_r  [CH_ENTRIES];
    logic [LHIST_W-1:0] lochist_f1_r;
    logic               choice_f1_r;

    logic [LI-1:0]      lht_rd_idx_s;
    logic [LI-1:0]      lht_wr_idx_s;
    logic [CI-1:0]      ch_rd_idx_s;
    logic [CI-1:0]      ch_wr_idx_s;
    logic [LHIST_W-1:0] lht_rd_val_s;
    logic [LHIST_W-1:0] lht_new_s;
    logic [LHIST_W-1:0] lht_f1_in_s;
    logic [CNT_W-1:0]   ch_rd_val_s;
    logic [CNT_W-1:0]   ch_new_s;
    logic               choice_f1_in_s;
    logic               lht_upd_s;
    logic               ch_upd_s;
    logic               sweep_lht_s;
    logic               sweep_ch_s;

    assign lht_rd_idx_s = bus.sp_pc_i[LI+1:2];
    assign ch_rd_idx_s  = bus.sp_pc_i[CI+1:2];
    assign lht_wr_idx_s = bus.cm_pc_i[LI+1:2];
    assign ch_wr_idx_s  = bus.cm_pc_i[CI+1:2];

    assign lht_rd_val_s = lht_r[lht_rd_idx_s];
    assign ch_rd_val_s  = ch_r[ch_rd_idx_s];
    assign lht_new_s    = hist_shift(lht_r[lht_wr_idx_s], bus.bpd_rt_brdir_i);
    assign ch_new_s     = sat_step(ch_r[ch_wr_idx_s], bus.bpd_rt_brdir_i ^ bus.bpd_ch_brdir_i);

    // The sweep covers the larger table; the smaller one stops being written past its depth.
    assign sweep_lht_s = (32'(sweep_cnt_r) < 32'(LHT_ENTRIES));
    assign sweep_ch_s  = (32'(sweep_cnt_r) < 32'(CH_ENTRIES));

    // Next-state logic: INIT leaves on the edge that writes the last sweep entry.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (sweep_cnt_r == SWEEP_LAST) state_s = ST_RUN;
                else                           state_s = ST_INIT;
            end
            ST_RUN:  state_s = ST_RUN;
            default: state_s = ST_INIT;
        endcase
    end

    // Retire updates only count once the tables are initialised and no reset is pending.
    always_comb begin
        lht_upd_s = 1'b0;
        ch_upd_s  = 1'b0;
        if (!reset && (state_r == ST_RUN)) begin
            lht_upd_s = bus.bpd_rt_we_i;
            ch_upd_s  = bus.bpd_rt_we_i & bus.bpd_ch_we_i;
        end else begin
            lht_upd_s = 1'b0;
            ch_upd_s  = 1'b0;
        end
    end

    // F1 input selection; the forwarding build swaps in the post-update value on a collision.
    always_comb begin
        lht_f1_in_s    = lht_rd_val_s;
        choice_f1_in_s = ch_rd_val_s[CNT_W-1];
`ifdef BPD0_BYPASS_EN
        if (lht_upd_s && (lht_wr_idx_s == lht_rd_idx_s)) lht_f1_in_s = lht_new_s;
        else                                             lht_f1_in_s = lht_rd_val_s;
        if (ch_upd_s && (ch_wr_idx_s == ch_rd_idx_s))    choice_f1_in_s = ch_new_s[CNT_W-1];
        else                                             choice_f1_in_s = ch_rd_val_s[CNT_W-1];
`endif
    end

    // FSM state, sweep counter and ready flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_INIT;
            sweep_cnt_r <= {SW{1'b0}};
            ready_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_r == ST_INIT) sweep_cnt_r <= sweep_cnt_r + SWEEP_ONE;
            ready_r <= (state_s == ST_RUN);
        end
    end

    // Local history table: cleared by the sweep, shifted by retiring branches.
    always_ff @(posedge clock) begin
        if (state_r == ST_INIT) begin
            if (sweep_lht_s) lht_r[sweep_cnt_r[LI-1:0]] <= {LHIST_W{1'b0}};
        end else if (lht_upd_s) begin
            lht_r[lht_wr_idx_s] <= lht_new_s;
        end
    end

    // Choice table: set to weakly-global by the sweep, trained when the predictors disagreed.
    always_ff @(posedge clock) begin
        if (state_r == ST_INIT) begin
            if (sweep_ch_s) ch_r[sweep_cnt_r[CI-1:0]] <= CNT_INIT;
        end else if (ch_upd_s) begin
            ch_r[ch_wr_idx_s] <= ch_new_s;
        end
    end

    // F1 pipeline registers: load on fetch advance in RUN, otherwise hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            lochist_f1_r <= {LHIST_W{1'b0}};
            choice_f1_r  <= 1'b0;
        end else if ((state_r == ST_RUN) && bus.load_fetch_i) begin
            lochist_f1_r <= lht_f1_in_s;
            choice_f1_r  <= choice_f1_in_s;
        end
    end

    assign bus.bpd_ready_o        = ready_r;
    assign bus.bpd_pht_choice_f1  = choice_f1_r;
    assign bus.bpd_bht_lochist_f1 = lochist_f1_r;

    bpd0_tourn_gen_chk u_chk (
        .clock  (clock),
        .reset  (reset),
        .ready  (ready_r),
        .in_run (state_r == ST_RUN)
    );
endmodule

// File: tb/tb_bpd0_tourn_gen.sv
// Randomised and directed bench for bpd0_tourn_gen against a table-level behavioural model.
module tb_bpd0_tourn_gen;
    localparam int N_LHT = 16;
    localparam int N_CH  = 32;
    localparam int N_SW  = 32;

    logic clock;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    bpd0_tourn_gen_if #(.PC_W(64), .LHIST_W(4)) bus ();

    bpd0_tourn_gen #(
        .PC_W(64), .LHT_ENTRIES(N_LHT), .LHIST_W(4), .CH_ENTRIES(N_CH), .CNT_W(2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: whole tables as integer arrays.
    int          lht_m [N_LHT];
    int          ch_m  [N_CH];
    int          sweep_m = 0;
    bit          ready_m = 1'b0;
    int          loch_m = 0;
    bit          chf1_m = 1'b0;
    bit          model_valid = 1'b0;

    function automatic int sat(input int c, input bit up);
        if (up) return (c < 3) ? c + 1 : 3;
        else    return (c > 0) ? c - 1 : 0;
    endfunction

    always @(posedge clock) begin : model
        int unsigned sp, cm;
        int li, ci, wl, wc, nl, nc;
        bit rt, chw, dir, up;
        sp  = bus.sp_pc_i[31:0];
        cm  = bus.cm_pc_i[31:0];
        li  = int'((sp % 64) / 4);
        ci  = int'((sp % 128) / 4);
        wl  = int'((cm % 64) / 4);
        wc  = int'((cm % 128) / 4);
        rt  = bus.bpd_rt_we_i;
        chw = bus.bpd_ch_we_i;
        dir = bus.bpd_rt_brdir_i;
        up  = bus.bpd_rt_brdir_i ^ bus.bpd_ch_brdir_i;
        if (reset) begin
            model_valid = 1'b1;
            sweep_m = 0;
            ready_m = 1'b0;
            loch_m  = 0;
            chf1_m  = 1'b0;
        end else if (!ready_m) begin
            sweep_m++;
            if (sweep_m == N_SW) begin
                ready_m = 1'b1;
                for (int i = 0; i < N_LHT; i++) lht_m[i] = 0;
                for (int i = 0; i < N_CH; i++)  ch_m[i]  = 2;
            end
        end else begin
            if (bus.load_fetch_i) begin
                nl = lht_m[li];
                nc = ch_m[ci];
`ifdef BPD0_BYPASS_EN
                if (rt && wl == li)        nl = (lht_m[wl] * 2 + int'(dir)) % 16;
                if (rt && chw && wc == ci) nc = sat(ch_m[wc], up);
`endif
                loch_m = nl;
                chf1_m = (nc >= 2);
            end
            if (rt) begin
                lht_m[wl] = (lht_m[wl] * 2 + int'(dir)) % 16;
                if (chw) ch_m[wc] = sat(ch_m[wc], up);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of all outputs against the model.
    always @(negedge clock) begin
        if (model_valid) begin
            check("ready",   32'(bus.bpd_ready_o),        32'(ready_m));
            check("lochist", 32'(bus.bpd_bht_lochist_f1), 32'(loch_m));
            check("choice",  32'(bus.bpd_pht_choice_f1),  32'(chf1_m));
        end
    end

    task automatic drive(input bit lf, input bit chwe, input bit chdir, input bit rtwe,
                         input bit rtdir, input logic [63:0] sp, input logic [63:0] cm);
        bus.load_fetch_i   = lf;
        bus.bpd_ch_we_i    = chwe;
        bus.bpd_ch_brdir_i = chdir;
        bus.bpd_rt_we_i    = rtwe;
        bus.bpd_rt_brdir_i = rtdir;
        bus.sp_pc_i        = sp;
        bus.cm_pc_i        = cm;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_rand(input bit force_upd);
        logic [63:0] sp, cm;
        sp = {$urandom, $urandom};
        cm = ($urandom_range(0, 1) == 1) ? sp : {$urandom, $urandom};
        drive($urandom_range(0, 1) == 1, force_upd | ($urandom_range(0, 1) == 1),
              $urandom_range(0, 1) == 1, force_upd | ($urandom_range(0, 2) != 0),
              $urandom_range(0, 1) == 1, sp, cm);
    endtask

    task automatic wait_ready(input bit busy, input string name);
        int n;
        n = 0;
        while (bus.bpd_ready_o !== 1'b1 && n < 100) begin
            if (busy) drive_rand(1'b1);
            else      drive(0, 0, 0, 0, 0, 64'h0, 64'h0);
            n++;
        end
        check(name, 32'(n), 32'(N_SW));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 64'h0, 64'h0);
        drive(0, 0, 0, 0, 0, 64'h0, 64'h0);
        check("reset_ready", 32'(bus.bpd_ready_o), 32'h0);
        check("reset_loch",  32'(bus.bpd_bht_lochist_f1), 32'h0);
        reset = 1'b0;
        wait_ready(1'b0, "init_latency");
        drive(1, 0, 0, 0, 0, 64'h10, 64'h0);
        check("init_loch", 32'(bus.bpd_bht_lochist_f1), 32'h0);
        check("init_choice", 32'(bus.bpd_pht_choice_f1), 32'h1);

        // Local history shifting and aliasing.
        drive(0, 0, 0, 1, 1, 64'h0, 64'h40);
        drive(0, 0, 0, 1, 0, 64'h0, 64'h40);
        drive(0, 0, 0, 1, 1, 64'h0, 64'h40);
        drive(0, 0, 0, 1, 1, 64'h0, 64'h40);
        drive(0, 0, 0, 1, 1, 64'h0, 64'h40);
        drive(1, 0, 0, 0, 0, 64'h40, 64'h0);
        check("lhist_0x40", 32'(bus.bpd_bht_lochist_f1), 32'h7);
        drive(1, 0, 0, 0, 0, 64'h80, 64'h0);
        check("lhist_alias", 32'(bus.bpd_bht_lochist_f1), 32'h7);

        // Choice counter saturation at both ends; ch_we without rt_we ignored.
        repeat (3) drive(0, 1, 1, 1, 1, 64'h0, 64'h4);
        drive(1, 0, 0, 0, 0, 64'h4, 64'h0);
        check("choice_low", 32'(bus.bpd_pht_choice_f1), 32'h0);
        repeat (4) drive(0, 1, 0, 1, 1, 64'h0, 64'h4);
        drive(1, 0, 0, 0, 0, 64'h4, 64'h0);
        check("choice_high", 32'(bus.bpd_pht_choice_f1), 32'h1);
        drive(0, 1, 1, 0, 1, 64'h0, 64'h4);
        drive(0, 1, 1, 1, 1, 64'h0, 64'h4);
        drive(1, 0, 0, 0, 0, 64'h4, 64'h0);
        check("choice_sat3", 32'(bus.bpd_pht_choice_f1), 32'h1);
        drive(0, 1, 1, 1, 1, 64'h0, 64'h4);
        drive(1, 0, 0, 0, 0, 64'h4, 64'h0);
        check("choice_dec", 32'(bus.bpd_pht_choice_f1), 32'h0);

        // Stall holds F1.
        drive(0, 0, 0, 1, 0, 64'h0, 64'h14);
        drive(0, 0, 0, 1, 1, 64'h0, 64'h14);
        drive(0, 0, 0, 1, 0, 64'h0, 64'h14);
        drive(0, 0, 0, 1, 1, 64'h0, 64'h14);
        drive(0, 0, 0, 1, 1, 64'h0, 64'h18);
        drive(0, 0, 0, 1, 0, 64'h0, 64'h18);
        drive(0, 0, 0, 1, 1, 64'h0, 64'h18);
        drive(0, 0, 0, 1, 0, 64'h0, 64'h18);
        drive(1, 0, 0, 0, 0, 64'h14, 64'h0);
        check("stall_pre", 32'(bus.bpd_bht_lochist_f1), 32'h5);
        drive(0, 0, 0, 0, 0, 64'h18, 64'h0);
        check("stall_hold", 32'(bus.bpd_bht_lochist_f1), 32'h5);
        drive(1, 0, 0, 0, 0, 64'h18, 64'h0);
        check("stall_release", 32'(bus.bpd_bht_lochist_f1), 32'hA);

        // Same-index read/update collision.
        drive(0, 0, 0, 1, 0, 64'h0, 64'hC);
        drive(0, 0, 0, 1, 0, 64'h0, 64'hC);
        drive(0, 0, 0, 1, 0, 64'h0, 64'hC);
        drive(0, 0, 0, 1, 1, 64'h0, 64'hC);
        drive(1, 0, 0, 1, 1, 64'hC, 64'hC);
`ifdef BPD0_BYPASS_EN
        check("collide", 32'(bus.bpd_bht_lochist_f1), 32'h3);
`else
        check("collide", 32'(bus.bpd_bht_lochist_f1), 32'h1);
`endif
        drive(1, 0, 0, 0, 0, 64'hC, 64'h0);
        check("collide_after", 32'(bus.bpd_bht_lochist_f1), 32'h3);

        // Random traffic with an occasional reset mid-run.
        for (int i = 0; i < 1500; i++) begin
            reset = (i == 700);
            drive_rand(1'b0);
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 64'h0, 64'h0);

        // Reset mid-sweep, with updates hammering the tables during INIT.
        reset = 1'b1;
        drive_rand(1'b1);
        reset = 1'b0;
        repeat (10) drive_rand(1'b1);
        reset = 1'b1;
        drive_rand(1'b1);
        reset = 1'b0;
        wait_ready(1'b1, "resweep_latency");
        for (int i = 0; i < N_CH; i++) begin
            drive(1, 0, 0, 0, 0, 64'(i * 4), 64'h0);
            check("resweep_loch", 32'(bus.bpd_bht_lochist_f1), 32'h0);
            check("resweep_choice", 32'(bus.bpd_pht_choice_f1), 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
